id_exe: RTL and testbench

- Decode-to-execute pipeline boundary. It registers the decoded instruction, the forwarded operands, and the writeback control from the decode stage, then presents them to the execute stage.
- Uses a valid/ready handshake on both sides. A 2-entry skid buffer lets execute stall (multi-cycle M ops) without a combinational ready path back into decode.
- Supports flush on branch/jump redirect.

---
 rtl/id_exe.sv | 134 +++++++++++++
 tb/tb_id_exe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe.sv
// Decode-to-execute pipeline register with a 2-entry skid buffer and redirect flush.
// Define ID_EXE_PERF_EN to enable the stall/bubble performance counters.
module id_exe #(
    parameter int unsigned          ADDR_WIDTH  = 32,
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          RDATA_WIDTH = 32,
    parameter int unsigned          RADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = 32'h00000013
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
    input  logic [DATA_WIDTH-1:0]  inst_i,
    input  logic [RDATA_WIDTH-1:0] op1_i,
    input  logic [RDATA_WIDTH-1:0] op2_i,
    input  logic                   reg_we_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [ADDR_WIDTH-1:0]  inst_addr_o,
    output logic [DATA_WIDTH-1:0]  inst_o,
    output logic [RDATA_WIDTH-1:0] op1_o,
    output logic [RDATA_WIDTH-1:0] op2_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic [31:0]            stall_cnt_o,
    output logic [31:0]            bubble_cnt_o
);

    localparam int unsigned PW = ADDR_WIDTH + DATA_WIDTH + 2 * RDATA_WIDTH + 1 + RADDR_WIDTH;
    localparam logic [PW-1:0] BUBBLE =
        {{ADDR_WIDTH{1'b0}}, NOP_INST, {(2 * RDATA_WIDTH + 1 + RADDR_WIDTH){1'b0}}};

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic [PW-1:0] in_payload;
    logic          accept, emit;

    assign in_payload = {inst_addr_i, inst_i, op1_i, op2_i, reg_we_i, reg_waddr_i};

    // ready_o is a pure function of state so execute's ready never reaches decode.
    assign ready_o = (state_q != StTwo);
    assign valid_o = (state_q == StOne) || (state_q == StTwo);
    assign accept  = valid_i & ready_o;
    assign emit    = valid_o & ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = StEmpty;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        main_d  = in_payload;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        main_d = in_payload;
                    end else if (accept) begin
                        state_d = StTwo;
                        skid_d  = in_payload;
                    end else if (emit) begin
                        state_d = StEmpty;
                        main_d  = BUBBLE;
                    end
                end
                StTwo: begin
                    if (emit) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StEmpty;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Main entry is bubble whenever empty, so outputs need no valid gating.
    assign {inst_addr_o, inst_o, op1_o, op2_o, reg_we_o, reg_waddr_o} = main_q;

`ifdef ID_EXE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (valid_o && !ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (!valid_o) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_exe.sv
// Self-checking bench for id_exe: directed scenarios plus randomized traffic
// compared against a 2-deep FIFO reference model.
module tb_id_exe;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_i;
    logic        ready_o, valid_o;
    logic [31:0] inst_addr_i, inst_i, op1_i, op2_i;
    logic        reg_we_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] inst_addr_o, inst_o, op1_o, op2_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] stall_cnt_o, bubble_cnt_o;

    always #5 clk = ~clk;

    id_exe dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .inst_addr_i  (inst_addr_i),
        .inst_i       (inst_i),
        .op1_i        (op1_i),
        .op2_i        (op2_i),
        .reg_we_i     (reg_we_i),
        .reg_waddr_i  (reg_waddr_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .inst_addr_o  (inst_addr_o),
        .inst_o       (inst_o),
        .op1_o        (op1_o),
        .op2_o        (op2_o),
        .reg_we_o     (reg_we_o),
        .reg_waddr_o  (reg_waddr_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        we;
        logic [4:0]  waddr;
    } pl_t;

    localparam logic [31:0] NOP = 32'h00000013;

    pl_t         q[$];
    int unsigned stall_exp, bubble_exp;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: a FIFO of capacity 2; head is what execute sees.
    task automatic model_edge();
        pl_t in;
        bit  room;
        in = '{addr: inst_addr_i, inst: inst_i, op1: op1_i, op2: op2_i,
               we: reg_we_i, waddr: reg_waddr_i};
        if (!rst_i) begin
            q.delete();
            stall_exp  = 0;
            bubble_exp = 0;
        end else begin
            if (q.size() > 0 && !ready_i) stall_exp++;
            if (q.size() == 0) bubble_exp++;
            if (flush_i) begin
                q.delete();
            end else begin
                room = (q.size() < 2);
                if (q.size() > 0 && ready_i) void'(q.pop_front());
                if (valid_i && room) q.push_back(in);
            end
        end
    endtask

    task automatic check_outputs();
        pl_t exp;
        if (q.size() > 0) exp = q[0];
        else exp = '{addr: 32'd0, inst: NOP, op1: 32'd0, op2: 32'd0, we: 1'b0, waddr: 5'd0};
        chk("valid_o", {31'd0, valid_o}, {31'd0, q.size() > 0});
        chk("ready_o", {31'd0, ready_o}, {31'd0, q.size() < 2});
        chk("inst_o", inst_o, exp.inst);
        chk("inst_addr_o", inst_addr_o, exp.addr);
        chk("op1_o", op1_o, exp.op1);
        chk("op2_o", op2_o, exp.op2);
        chk("reg_we_o", {31'd0, reg_we_o}, {31'd0, exp.we});
        chk("reg_waddr_o", {27'd0, reg_waddr_o}, {27'd0, exp.waddr});
`ifdef ID_EXE_PERF_EN
        chk("stall_cnt_o", stall_cnt_o, stall_exp);
        chk("bubble_cnt_o", bubble_cnt_o, bubble_exp);
`else
        chk("stall_cnt_o", stall_cnt_o, 32'd0);
        chk("bubble_cnt_o", bubble_cnt_o, 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic we,
                         input logic [4:0] waddr);
        valid_i     = v;
        inst_i      = inst;
        reg_we_i    = we;
        reg_waddr_i = waddr;
        inst_addr_i = $urandom;
        op1_i       = $urandom;
        op2_i       = $urandom;
    endtask

    initial begin
        rst_i   = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        q.delete();
        stall_exp  = 0;
        bubble_exp = 0;

        // Reset state
        step();
        step();
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_inst", inst_o, NOP);

        // Stream of three with ready_i=1
        rst_i = 1'b1;
        drive(1'b1, 32'h00500093, 1'b1, 5'd1);
        step();
        chk("stream0", inst_o, 32'h00500093);
        drive(1'b1, 32'h00A00113, 1'b1, 5'd2);
        step();
        chk("stream1", inst_o, 32'h00A00113);
        drive(1'b1, 32'h002081B3, 1'b1, 5'd3);
        step();
        chk("stream2", inst_o, 32'h002081B3);
        chk("stream_ready", {31'd0, ready_o}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        step();
        chk("stream_drain", {31'd0, valid_o}, 32'd0);

        // Stall into skid
        ready_i = 1'b0;
        drive(1'b1, 32'h00100093, 1'b1, 5'd1);
        step();
        drive(1'b1, 32'h00200113, 1'b1, 5'd2);
        step();
        chk("skid_ready", {31'd0, ready_o}, 32'd0);
        chk("skid_holdA", inst_o, 32'h00100093);
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        ready_i = 1'b1;
        step();
        chk("skid_B", inst_o, 32'h00200113);
        step();
        chk("skid_empty", {31'd0, valid_o}, 32'd0);
        chk("skid_nop", inst_o, NOP);

        // Flush while full, with a concurrent input that must be dropped
        ready_i = 1'b0;
        drive(1'b1, 32'h00100093, 1'b1, 5'd1);
        step();
        drive(1'b1, 32'h00200113, 1'b1, 5'd2);
        step();
        flush_i = 1'b1;
        drive(1'b1, 32'h00300193, 1'b1, 5'd3);
        step();
        flush_i = 1'b0;
        chk("flush_valid", {31'd0, valid_o}, 32'd0);
        chk("flush_ready", {31'd0, ready_o}, 32'd1);
        chk("flush_nop", inst_o, NOP);
        chk("flush_we", {31'd0, reg_we_o}, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        ready_i = 1'b1;
        step();
        step();

        // Reset while holding one entry
        ready_i = 1'b0;
        drive(1'b1, 32'h00100093, 1'b1, 5'd3);
        step();
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("mid_rst_we", {31'd0, reg_we_o}, 32'd0);
        chk("mid_rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
        chk("mid_rst_op1", op1_o, 32'd0);

        // Simultaneous accept and emit while holding one
        drive(1'b1, 32'h00100093, 1'b0, 5'd0);
        step();
        ready_i = 1'b1;
        drive(1'b1, 32'h00200113, 1'b0, 5'd0);
        step();
        chk("acc_emit_inst", inst_o, 32'h00200113);
        chk("acc_emit_ready", {31'd0, ready_o}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        step();

        // Perf counters: 3 cycles with valid_o=0, then 4 stalled cycles
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        step();
        ready_i = 1'b0;
        drive(1'b1, 32'h00100093, 1'b0, 5'd0);
        step();
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) step();
`ifdef ID_EXE_PERF_EN
        chk("perf_bubble", bubble_cnt_o, 32'd3);
        chk("perf_stall", stall_cnt_o, 32'd4);
`else
        chk("perf_bubble", bubble_cnt_o, 32'd0);
        chk("perf_stall", stall_cnt_o, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom), 5'($urandom));
            ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 31) == 0);
            rst_i   = ($urandom_range(0, 127) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
